// File: rtl/ps2_host_port.sv
// PS/2 host port: line engine (RX, request-to-send, TX with retry), RX/TX
// byte FIFOs, sticky status flags, error counter and a level interrupt, all
// reachable over a byte-wide MMIO bus.
// Ports:
//   main_clk, reset            - system clock, synchronous active-high reset
//   external_clock_in/data_in  - raw PS/2 lines (synchronised internally)
//   external_*_pulldown        - open-drain drives, 1 = pull the line low
//   address_mmio, data_write_mmio, is_mmio_write - MMIO write side
//   data_read_mmio             - combinational read data for address_mmio
//   irq                        - registered level interrupt

// Byte FIFO holding up to 2^AW-1 entries; full is count == all ones.
module ps2_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    head,
  output logic [AW-1:0] count,
  output logic          empty,
  output logic          dropped
);
  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wp_q, rp_q, cnt_q;
  logic          full, push_ok, pop_ok;

  assign full    = &cnt_q;
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
  assign push_ok = push & (~full | pop_ok);
  assign dropped = push & ~push_ok;
  assign head    = mem_q[rp_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + AW'(1);
      if (pop_ok)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + AW'(push_ok) - AW'(pop_ok);
    end
  end
endmodule

module ps2_host_port #(
  parameter int CLK_HZ        = 90000000,
  parameter int RX_DEPTH_LOG2 = 8,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int INHIBIT_US    = 500,
  parameter int RTS_DATA_US   = 30,
  parameter int SAMPLE_US     = 15,
  parameter int TIMEOUT_US    = 511,
  parameter int RETRY_LIMIT   = 3
) (
  input  logic       main_clk,
  input  logic       reset,
  input  logic       external_clock_in,
  input  logic       external_data_in,
  output logic       external_clock_pulldown,
  output logic       external_data_pulldown,
  input  logic [2:0] address_mmio,
  input  logic [7:0] data_write_mmio,
  input  logic       is_mmio_write,
  output logic [7:0] data_read_mmio,
  output logic       irq
);
  localparam int DIV = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RX, S_RTS, S_TX} state_e;

  state_e      st_q, st_d;
  logic [DW-1:0] div_q;
  logic        tick;
  logic        ck_m_q, ck_s_q, dt_m_q, dt_s_q, ckprev_q, ckprev_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  sr_q, sr_d;
  logic [15:0] smp_q, smp_d, gap_q, gap_d, rts_q, rts_d;
  logic        pend_q, pend_d, ckpd_q, ckpd_d, dtpd_q, dtpd_d;
  logic [7:0]  tries_q, tries_d, ecnt_q, ecnt_d;
  logic        conn_q, conn_d, rxdrop_q, rxdrop_d, txfail_q, txfail_d, ferr_q, ferr_d;
  logic [1:0]  ien_q, ien_d;
  logic        irq_q, irq_d;

  logic        fall, act, tmo, fail;
  logic        eng_rx_push, eng_tx_pop, set_conn, clr_conn, set_txfail, set_ferr, err_inc;
  logic        rx_pop, tx_push, ien_we, ecnt_clr;
  logic [2:0]  w1c;
  logic [7:0]  rx_head, tx_head;
  logic [RX_DEPTH_LOG2-1:0] rx_cnt;
  logic [TX_DEPTH_LOG2-1:0] tx_cnt;
  logic        rx_empty, tx_empty, rx_drop, tx_drop;

  assign tick = (div_q == DW'(DIV - 1));

  assign rx_pop   = is_mmio_write && address_mmio == 3'd0;
  assign tx_push  = is_mmio_write && address_mmio == 3'd1;
  assign ien_we   = is_mmio_write && address_mmio == 3'd5;
  assign ecnt_clr = is_mmio_write && address_mmio == 3'd6;
  assign w1c      = (is_mmio_write && address_mmio == 3'd4) ? data_write_mmio[3:1] : 3'b000;

  ps2_fifo #(.AW(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(main_clk), .rst(reset), .push(eng_rx_push), .pop(rx_pop), .din(sr_q[8:1]),
    .head(rx_head), .count(rx_cnt), .empty(rx_empty), .dropped(rx_drop)
  );

  ps2_fifo #(.AW(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(main_clk), .rst(reset), .push(tx_push), .pop(eng_tx_pop), .din(data_write_mmio),
    .head(tx_head), .count(tx_cnt), .empty(tx_empty), .dropped(tx_drop)
  );

  // Line engine: everything below advances only on the microsecond tick.
  always_comb begin
    st_d = st_q; bit_d = bit_q; sr_d = sr_q; smp_d = smp_q; pend_d = pend_q;
    gap_d = gap_q; rts_d = rts_q; tries_d = tries_q; ckpd_d = ckpd_q; dtpd_d = dtpd_q;
    ckprev_d = ckprev_q;
    fall = 1'b0; act = 1'b0; tmo = 1'b0; fail = 1'b0;
    eng_rx_push = 1'b0; eng_tx_pop = 1'b0; set_conn = 1'b0; clr_conn = 1'b0;
    set_txfail = 1'b0; set_ferr = 1'b0; err_inc = 1'b0;
    if (tick) begin
      ckprev_d = ck_s_q;
      fall = ckprev_q & ~ck_s_q;
      act  = pend_q && smp_q == '0;
      tmo  = gap_q > 16'(TIMEOUT_US);
      if (pend_q && smp_q != '0) smp_d = smp_q - 16'd1;
      if (st_q == S_RX || st_q == S_TX) begin
        // Gap counter restarts on any clock transition inside a frame.
        gap_d = (ckprev_q ^ ck_s_q) ? '0 : gap_q + 16'd1;
        if (fall && !pend_q) begin pend_d = 1'b1; smp_d = 16'(SAMPLE_US - 1); end
        if (act) begin pend_d = 1'b0; bit_d = bit_q + 4'd1; end
      end
      case (st_q)
        S_IDLE: begin
          ckpd_d = 1'b0; dtpd_d = 1'b0;
          // Falling edge with data low is the device's start bit; RX wins over TX.
          if (fall && !dt_s_q) begin
            st_d = S_RX; bit_d = '0; pend_d = 1'b1; smp_d = 16'(SAMPLE_US - 1); gap_d = '0;
          end else if (!tx_empty && ck_s_q) begin
            st_d = S_RTS; rts_d = '0; ckpd_d = 1'b1;
          end
        end
        S_RTS: begin
          rts_d  = rts_q + 16'd1;
          ckpd_d = 1'b1;
          dtpd_d = rts_q >= 16'(INHIBIT_US - RTS_DATA_US);
          if (rts_q == 16'(INHIBIT_US - 1)) begin
            // Release clock, keep data low as the start bit.
            ckpd_d = 1'b0; dtpd_d = 1'b1; st_d = S_TX; bit_d = '0; pend_d = 1'b0; gap_d = '0;
          end
        end
        S_RX: begin
          if (act) begin
            // Samples shift in from the top: after 10 samples sr_q = {par, d7..d0, start}.
            sr_d = {dt_s_q, sr_q[9:1]};
            if (bit_q == 4'd10) begin
              st_d = S_IDLE;
              if (!sr_q[0] && dt_s_q && (^sr_q[9:1])) begin
                eng_rx_push = 1'b1; set_conn = 1'b1;
              end else begin
                set_ferr = 1'b1; err_inc = 1'b1;
              end
            end
          end else if (tmo) begin
            st_d = S_IDLE; set_ferr = 1'b1; err_inc = 1'b1;
          end
        end
        S_TX: begin
          if (act) begin
            if (bit_q < 4'd8)        dtpd_d = ~tx_head[bit_q[2:0]];
            else if (bit_q == 4'd8)  dtpd_d = ^tx_head;   // low when odd parity bit is 0
            else if (bit_q == 4'd9)  dtpd_d = 1'b0;       // stop bit: release
            else if (dt_s_q)         fail = 1'b1;         // no ACK
            else begin
              eng_tx_pop = 1'b1; set_conn = 1'b1; tries_d = '0; st_d = S_IDLE;
            end
          end else if (tmo) begin
            fail = 1'b1;
          end
          // Every failed attempt counts as an error; the last one also drops the byte.
          if (fail) begin
            err_inc = 1'b1; dtpd_d = 1'b0;
            if (tries_q == 8'(RETRY_LIMIT - 1)) begin
              eng_tx_pop = 1'b1; set_txfail = 1'b1; clr_conn = 1'b1;
              tries_d = '0; st_d = S_IDLE; ckpd_d = 1'b0;
            end else begin
              tries_d = tries_q + 8'd1; st_d = S_RTS; rts_d = '0; ckpd_d = 1'b1;
            end
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  // Status, enables, error count and interrupt. A new flag set beats W1C.
  always_comb begin
    rxdrop_d = (rxdrop_q & ~w1c[0]) | rx_drop;
    txfail_d = (txfail_q & ~w1c[1]) | set_txfail | tx_drop;
    ferr_d   = (ferr_q & ~w1c[2]) | set_ferr;
    conn_d   = set_conn | (conn_q & ~clr_conn);
    ien_d    = ien_we ? data_write_mmio[1:0] : ien_q;
    ecnt_d   = ecnt_q;
    if (ecnt_clr)                        ecnt_d = err_inc ? 8'd1 : 8'd0;
    else if (err_inc && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
    irq_d = (ien_q[0] & ~rx_empty) | (ien_q[1] & (rxdrop_q | txfail_q | ferr_q));
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      div_q <= '0; st_q <= S_IDLE;
      ck_m_q <= 1'b1; ck_s_q <= 1'b1; dt_m_q <= 1'b1; dt_s_q <= 1'b1; ckprev_q <= 1'b1;
      bit_q <= '0; sr_q <= '0; smp_q <= '0; gap_q <= '0; rts_q <= '0; pend_q <= 1'b0;
      ckpd_q <= 1'b0; dtpd_q <= 1'b0; tries_q <= '0; ecnt_q <= '0;
      conn_q <= 1'b0; rxdrop_q <= 1'b0; txfail_q <= 1'b0; ferr_q <= 1'b0;
      ien_q <= '0; irq_q <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DW'(1);
      ck_m_q <= external_clock_in; ck_s_q <= ck_m_q;
      dt_m_q <= external_data_in;  dt_s_q <= dt_m_q;
      st_q <= st_d; ckprev_q <= ckprev_d; bit_q <= bit_d; sr_q <= sr_d; smp_q <= smp_d;
      gap_q <= gap_d; rts_q <= rts_d; pend_q <= pend_d; ckpd_q <= ckpd_d; dtpd_q <= dtpd_d;
      tries_q <= tries_d; ecnt_q <= ecnt_d;
      conn_q <= conn_d; rxdrop_q <= rxdrop_d; txfail_q <= txfail_d; ferr_q <= ferr_d;
      ien_q <= ien_d; irq_q <= irq_d;
    end
  end

  always_comb begin
    data_read_mmio = 8'h00;
    case (address_mmio)
      3'd0:    data_read_mmio = rx_empty ? 8'h00 : rx_head;
      3'd2:    data_read_mmio = 8'(rx_cnt);
      3'd3:    data_read_mmio = 8'(tx_cnt);
      3'd4:    data_read_mmio = {3'b000, st_q != S_IDLE, ferr_q, txfail_q, rxdrop_q, conn_q};
      3'd5:    data_read_mmio = {6'b0, ien_q};
      3'd6:    data_read_mmio = ecnt_q;
      default: data_read_mmio = 8'h00;
    endcase
  end

  assign external_clock_pulldown = ckpd_q;
  assign external_data_pulldown  = dtpd_q;
  assign irq                     = irq_q;
endmodule

// File: tb/tb_ps2_host_port.sv
// Bench for ps2_host_port: a behavioural PS/2 device drives/receives frames,
// a queue-based model tracks FIFO contents, flags and the error count, and
// MMIO reads are compared against the model.
`timescale 1ns/1ns
module tb_ps2_host_port;
  localparam int US   = 1000;
  localparam int HALF = 20 * US;

  logic       main_clk = 1'b0, reset = 1'b1;
  logic       dev_ck_low = 1'b0, dev_dt_low = 1'b0;
  logic       ck_line, dt_line;
  logic       external_clock_pulldown, external_data_pulldown, irq;
  logic [2:0] address_mmio = '0;
  logic [7:0] data_write_mmio = '0, data_read_mmio;
  logic       is_mmio_write = 1'b0;

  assign ck_line = ~(external_clock_pulldown | dev_ck_low);
  assign dt_line = ~(external_data_pulldown | dev_dt_low);

  ps2_host_port #(
    .CLK_HZ(2000000), .RX_DEPTH_LOG2(2), .TX_DEPTH_LOG2(2), .INHIBIT_US(50),
    .RTS_DATA_US(10), .SAMPLE_US(3), .TIMEOUT_US(60), .RETRY_LIMIT(3)
  ) dut (
    .main_clk(main_clk), .reset(reset),
    .external_clock_in(ck_line), .external_data_in(dt_line),
    .external_clock_pulldown(external_clock_pulldown),
    .external_data_pulldown(external_data_pulldown),
    .address_mmio(address_mmio), .data_write_mmio(data_write_mmio),
    .is_mmio_write(is_mmio_write), .data_read_mmio(data_read_mmio), .irq(irq)
  );

  always #250 main_clk = ~main_clk;  // 2 MHz

  int errors = 0, checks = 0;

  // Reference model
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  bit m_conn, m_drop, m_fail, m_ferr;
  int m_ecnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge main_clk);
    address_mmio = a;
    #1 d = data_read_mmio;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge main_clk);
    address_mmio = a; data_write_mmio = d; is_mmio_write = 1'b1;
    @(negedge main_clk);
    is_mmio_write = 1'b0;
  endtask

  task automatic model_reset();
    m_rx.delete(); m_tx.delete();
    m_conn = 0; m_drop = 0; m_fail = 0; m_ferr = 0; m_ecnt = 0;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    rd(3'd2, d); chk({tag, ".rxcnt"}, d, m_rx.size());
    rd(3'd4, d); chk({tag, ".status"}, d, {3'b0, 1'b0, m_ferr, m_fail, m_drop, m_conn});
    rd(3'd6, d); chk({tag, ".ecnt"}, d, m_ecnt);
    if (m_rx.size() > 0) begin
      rd(3'd0, d); chk({tag, ".head"}, d, m_rx[0]);
    end
  endtask

  // Device -> host frame; model applies the frame rules at byte level.
  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_dt_low = ~f[i];
      #(HALF/2); dev_ck_low = 1'b1;
      #(HALF);   dev_ck_low = 1'b0;
      #(HALF/2);
    end
    dev_dt_low = 1'b0;
    #(2*HALF);
    if (bad) begin m_ferr = 1; m_ecnt++; end
    else begin
      m_conn = 1;
      if (m_rx.size() < 3) m_rx.push_back(b); else m_drop = 1;
    end
  endtask

  task automatic wait_pd(input logic lvl, output bit ok);
    ok = 0;
    for (int n = 0; n < 4000; n++) begin
      if (external_clock_pulldown === lvl) begin ok = 1; return; end
      @(negedge main_clk);
    end
  endtask

  // Host -> device frame: v[7:0] data, v[8] parity, v[9] stop, v[10] ACK level.
  task automatic recv_frame(input bit ack, output logic [10:0] v);
    bit ok1, ok2;
    v = '0;
    wait_pd(1'b1, ok1); wait_pd(1'b0, ok2);
    chk("rts_seen", ok1 & ok2, 1);
    if (!(ok1 & ok2)) return;
    #(HALF/2);
    for (int k = 0; k < 11; k++) begin
      if (k == 10 && ack) dev_dt_low = 1'b1;
      dev_ck_low = 1'b1; #(HALF);
      v[k] = dt_line;
      dev_ck_low = 1'b0; #(HALF);
    end
    dev_dt_low = 1'b0;
    #(HALF);
  endtask

  task automatic tx_expect(input string tag, input logic [10:0] v);
    logic [7:0] b;
    b = m_tx.pop_front();
    chk({tag, ".data"}, v[7:0], b);
    chk({tag, ".par"}, v[8], ~^b);
    chk({tag, ".stop"}, v[9], 1'b1);
    m_conn = 1;
  endtask

  initial begin
    #(100_000_000);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d, b;
    logic [10:0] v;
    bit          bad, pd, prev;
    int          len, rises;

    model_reset();
    repeat (4) @(negedge main_clk);
    reset = 1'b0;
    chk("rst.ckpd", external_clock_pulldown, 0);
    chk("rst.dtpd", external_data_pulldown, 0);
    chk("rst.irq", irq, 0);
    check_regs("rst");

    // Single frame 0xAA with RX-nonempty interrupt
    wr(3'd5, 8'h01);
    send_frame(8'hAA, 0);
    check_regs("aa");
    chk("aa.irq", irq, 1);
    wr(3'd0, 8'h00); void'(m_rx.pop_front());
    rd(3'd2, d); chk("aa.popcnt", d, 0);
    chk("aa.irq_off", irq, 0);
    wr(3'd5, 8'h00);

    // Overflow at depth 3
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 0);
    check_regs("ovf");
    wr(3'd4, 8'h02); m_drop = 0;
    check_regs("ovf_w1c");
    for (int i = 1; i <= 3; i++) begin
      rd(3'd0, d); chk("ovf.order", d, i);
      wr(3'd0, 8'h00); void'(m_rx.pop_front());
    end

    // Randomised RX traffic with random pops
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, bad);
      check_regs("rnd");
      if (m_rx.size() > 0 && $urandom_range(0, 1) == 1) begin
        wr(3'd0, 8'h00); void'(m_rx.pop_front());
      end
    end
    while (m_rx.size() > 0) begin
      rd(3'd0, d); chk("drain", d, m_rx[0]);
      wr(3'd0, 8'h00); void'(m_rx.pop_front());
    end
    wr(3'd4, 8'h0E); m_drop = 0; m_fail = 0; m_ferr = 0;
    check_regs("clr");

    // Host transmit 0xFF, ACKed
    wr(3'd1, 8'hFF); m_tx.push_back(8'hFF);
    rd(3'd3, d); chk("tx.cnt1", d, 1);
    recv_frame(1, v);
    tx_expect("txff", v);
    rd(3'd3, d); chk("tx.cnt0", d, 0);
    check_regs("txff");

    // TX FIFO full: 4 random pushes, 4th dropped, first 3 sent in order
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      wr(3'd1, b);
      if (i < 3) m_tx.push_back(b); else m_fail = 1;
    end
    rd(3'd3, d); chk("txfull.cnt", d, 3);
    for (int i = 0; i < 3; i++) begin
      recv_frame(1, v);
      tx_expect("txrnd", v);
    end
    rd(3'd3, d); chk("txrnd.cnt0", d, 0);
    check_regs("txrnd");
    wr(3'd4, 8'h04); m_fail = 0;

    // Device never clocks: three RTS attempts then give up
    wr(3'd6, 8'h00); m_ecnt = 0;
    wr(3'd1, 8'h3C);
    prev = 0; len = 0; rises = 0; d = 8'h10;
    for (int n = 0; n < 4000; n++) begin
      rd(3'd4, d);
      pd = external_clock_pulldown;
      if (pd) len++;
      if (!pd && prev) begin
        rises++;
        chk("rts.len_ok", (len >= 95 && len <= 105), 1);
        len = 0;
      end
      prev = pd;
      if (n > 4 && !d[4]) break;
    end
    chk("noclk.idle", d[4], 0);
    chk("noclk.attempts", rises, 3);
    m_fail = 1; m_conn = 0; m_ecnt = 3;
    rd(3'd3, d); chk("noclk.txcnt", d, 0);
    check_regs("noclk");

    // Parity error, then error interrupt
    send_frame(8'h5A, 1);
    check_regs("perr");
    wr(3'd5, 8'h02);
    @(negedge main_clk);
    chk("err.irq", irq, 1);
    wr(3'd4, 8'h0E); m_fail = 0; m_ferr = 0;
    repeat (2) @(negedge main_clk);
    chk("err.irq_off", irq, 0);

    // Reset in the middle of a TX frame while data is driven low
    wr(3'd1, 8'h00);
    wait_pd(1'b1, bad); wait_pd(1'b0, bad);
    #(HALF/2);
    for (int k = 0; k < 4; k++) begin
      dev_ck_low = 1'b1; #(HALF); dev_ck_low = 1'b0; #(HALF);
    end
    dev_ck_low = 1'b1; #(5*US);
    chk("midtx.dtpd", external_data_pulldown, 1);
    @(negedge main_clk); reset = 1'b1;
    @(posedge main_clk); #1;
    chk("midrst.ckpd", external_clock_pulldown, 0);
    chk("midrst.dtpd", external_data_pulldown, 0);
    chk("midrst.irq", irq, 0);
    dev_ck_low = 1'b0;
    repeat (3) @(negedge main_clk);
    reset = 1'b0;
    model_reset();
    check_regs("midrst");
    rd(3'd3, d); chk("midrst.txcnt", d, 0);
    rd(3'd5, d); chk("midrst.ien", d, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
